// File: rtl/ram_loader_if.sv
// Load/execution bus between the RAM loader, its program source and the RAM.
// The slave modport is the loader's view; master is the driver/observer side.
interface ram_loader_if;
  logic       i_start;
  logic [3:0] i_last_addr;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic [3:0] i_mar_address;
  logic       i_ram_read;
  logic       o_program_mode;
  logic [7:0] o_program_data;
  logic [3:0] o_address;
  logic       o_ram_enable;
  logic       o_busy;
  logic       o_done;
  logic [4:0] o_words_loaded;
  logic       o_conflict;

  modport slave (
    input  i_start, i_last_addr, i_valid, i_data, i_mar_address, i_ram_read,
    output o_ready, o_program_mode, o_program_data, o_address, o_ram_enable,
    output o_busy, o_done, o_words_loaded, o_conflict
  );

  modport master (
    output i_start, i_last_addr, i_valid, i_data, i_mar_address, i_ram_read,
    input  o_ready, o_program_mode, o_program_data, o_address, o_ram_enable,
    input  o_busy, o_done, o_words_loaded, o_conflict
  );
endinterface

// File: rtl/ram_loader.sv
// Streams program bytes into a 16x8 RAM through its program port, then hands
// the RAM address/enable over to the execution-mode MAR path.
module ram_loader (
  input  logic        i_clk,
  input  logic        i_reset,
  ram_loader_if.slave bus
);
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_SETUP,
    S_COMMIT,
    S_DONE,
    S_RUN
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic [ADDR_W-1:0] last_addr, last_addr_nx;
  logic [DATA_W-1:0] byte_q, byte_nx;

  logic              ready_q, ready_nx;
  logic              busy_q, busy_nx;
  logic              done_q, done_nx;
  logic              mode_q, mode_nx;
  logic [DATA_W-1:0] pdata_q, pdata_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic              en_q, en_nx;
  logic [CNT_W-1:0]  words_q, words_nx;
  logic              conflict_q, conflict_nx;

  logic start_ok;
  logic in_busy;

  assign start_ok = bus.i_start && (state == S_IDLE || state == S_RUN);
  assign in_busy  = (state == S_ACCEPT) || (state == S_SETUP) || (state == S_COMMIT);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and next values of every registered output; outputs are
  // decoded from the state being entered so they line up with that state.
  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    last_addr_nx = last_addr;
    byte_nx      = byte_q;
    words_nx     = words_q;
    conflict_nx  = conflict_q;
    ready_nx     = 1'b0;
    busy_nx      = 1'b0;
    done_nx      = 1'b0;
    mode_nx      = 1'b1;
    pdata_nx     = pdata_q;
    addr_nx      = addr_q;
    en_nx        = 1'b0;

    unique case (state)
      S_IDLE, S_RUN: begin
        if (start_ok) begin
          state_nx     = S_ACCEPT;
          last_addr_nx = bus.i_last_addr;
          ptr_nx       = '0;
          words_nx     = '0;
          conflict_nx  = 1'b0;
        end
      end
      S_ACCEPT: begin
        if (bus.i_valid) begin
          byte_nx  = bus.i_data;
          state_nx = S_SETUP;
        end
      end
      S_SETUP: begin
        state_nx = S_COMMIT;
      end
      S_COMMIT: begin
        if (ptr == last_addr) begin
          state_nx = S_DONE;
        end else begin
          ptr_nx   = ptr + 1'b1;
          state_nx = S_ACCEPT;
        end
      end
      S_DONE: begin
        state_nx = S_RUN;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    if (in_busy && bus.i_ram_read) begin
      conflict_nx = 1'b1;
    end

    // The RAM latches program data when its address moves while in program
    // mode, so SETUP parks on ~ptr and COMMIT steps onto ptr.
    unique case (state_nx)
      S_IDLE: begin
        addr_nx = '0;
      end
      S_ACCEPT: begin
        ready_nx = 1'b1;
        busy_nx  = 1'b1;
      end
      S_SETUP: begin
        busy_nx  = 1'b1;
        mode_nx  = 1'b0;
        pdata_nx = byte_nx;
        addr_nx  = ~ptr_nx;
      end
      S_COMMIT: begin
        busy_nx  = 1'b1;
        mode_nx  = 1'b0;
        addr_nx  = ptr_nx;
        words_nx = words_q + 1'b1;
      end
      S_DONE: begin
        done_nx = 1'b1;
        addr_nx = ptr_nx;
      end
      S_RUN: begin
        if (state == S_RUN) begin
          addr_nx = bus.i_mar_address;
          en_nx   = bus.i_ram_read;
        end
      end
      default: begin
        addr_nx = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr        <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mode_q     <= 1'b1;
      pdata_q    <= '0;
      addr_q     <= '0;
      en_q       <= 1'b0;
      words_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      ptr        <= ptr_nx;
      ready_q    <= ready_nx;
      busy_q     <= busy_nx;
      done_q     <= done_nx;
      mode_q     <= mode_nx;
      pdata_q    <= pdata_nx;
      addr_q     <= addr_nx;
      en_q       <= en_nx;
      words_q    <= words_nx;
      conflict_q <= conflict_nx;
    end
  end

  // Captured byte and load bound are only meaningful after an accepted start.
  always_ff @(posedge i_clk) begin
    byte_q    <= byte_nx;
    last_addr <= last_addr_nx;
  end

  assign bus.o_ready        = ready_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;
  assign bus.o_program_mode = mode_q;
  assign bus.o_program_data = pdata_q;
  assign bus.o_address      = addr_q;
  assign bus.o_ram_enable   = en_q;
  assign bus.o_words_loaded = words_q;
  assign bus.o_conflict     = conflict_q;
endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: a RAM model observes program-port writes and
// a monitor compares them, and done pulses, against queued expectations.
module tb_ram_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  ram_loader_if bus();

  ram_loader dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] model_ram [16];
  logic [7:0] mirror    [16];
  logic [3:0] exp_wa [$];
  logic [7:0] exp_wd [$];
  int         exp_done [$];
  logic [7:0] src_q [$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         start_cyc = 0;
  logic [3:0] mdl_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: a write is an address step while program mode stays low.
  initial begin
    logic       prev_mode;
    logic [3:0] prev_addr;
    prev_mode = 1'b1;
    prev_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.o_program_mode == 1'b0 && prev_mode == 1'b0 && bus.o_address != prev_addr) begin
        mirror[bus.o_address] = bus.o_program_data;
        if (exp_wa.size() == 0) begin
          chk("write_expected", exp_wa.size(), 1);
        end else begin
          chk("write_addr", bus.o_address, exp_wa.pop_front());
          chk("write_data", bus.o_program_data, exp_wd.pop_front());
        end
      end
      if (bus.o_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_done.size() == 0) begin
          chk("done_expected", exp_done.size(), 1);
        end else begin
          chk("words_at_done", bus.o_words_loaded, exp_done.pop_front());
        end
      end
      prev_mode = bus.o_program_mode;
      prev_addr = bus.o_address;
    end
  end

  task automatic start_load(input logic [3:0] last, input bit expect_done);
    bus.i_start     = 1'b1;
    bus.i_last_addr = last;
    @(negedge clk);
    bus.i_start = 1'b0;
    start_cyc   = cyc;
    mdl_ptr     = '0;
    if (expect_done) exp_done.push_back(int'(last) + 1);
  endtask

  // Sends n bytes from src_q; stall_max < 0 means i_valid held with no stalls.
  task automatic run_bytes(input int n, input int stall_max, input int poke_k);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      int         t;
      b = src_q.pop_front();
      if (stall_max >= 0) bus.i_valid = 1'b0;
      t = 0;
      while (!bus.o_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) chk("ready_timeout", t, 0);
      if (stall_max > 0) repeat (stall_max) @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_data  = b;
      exp_wa.push_back(mdl_ptr);
      exp_wd.push_back(b);
      model_ram[mdl_ptr] = b;
      mdl_ptr++;
      @(negedge clk);
      if (k == poke_k) begin
        bus.i_start     = 1'b1;
        bus.i_last_addr = 4'hF;
        @(negedge clk);
        bus.i_start = 1'b0;
      end
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int t;
    t = 0;
    while (done_cnt == prev && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", done_cnt, prev + 1);
    @(negedge clk);
  endtask

  task automatic fill_src(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    int d0;
    logic [3:0] a;
    logic [3:0] last;
    for (int i = 0; i < 16; i++) begin
      model_ram[i] = '0;
      mirror[i]    = '0;
    end
    bus.i_start = 0; bus.i_last_addr = 0; bus.i_valid = 0; bus.i_data = 0;
    bus.i_mar_address = 0; bus.i_ram_read = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", bus.o_ready, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_mode", bus.o_program_mode, 1);
    chk("rst_pdata", bus.o_program_data, 0);
    chk("rst_addr", bus.o_address, 0);
    chk("rst_en", bus.o_ram_enable, 0);
    chk("rst_words", bus.o_words_loaded, 0);
    chk("rst_conflict", bus.o_conflict, 0);
    repeat (3) @(negedge clk);
    chk("idle_stays", bus.o_busy, 0);

    // Full 16-byte load with i_valid held.
    for (int i = 0; i < 16; i++) src_q.push_back(8'(8'h10 + i));
    d0 = done_cnt;
    start_load(4'hF, 1);
    chk("busy_after_start", bus.o_busy, 1);
    run_bytes(16, -1, -1);
    wait_done(d0);
    chk("full_latency", done_cyc - start_cyc, 48);
    chk("full_words", bus.o_words_loaded, 16);
    chk("full_ram15", mirror[15], 8'h1F);

    // Short load with two stall cycles before each byte.
    src_q.push_back(8'hA5); src_q.push_back(8'h5A); src_q.push_back(8'hFF);
    d0 = done_cnt;
    start_load(4'd2, 1);
    run_bytes(3, 2, -1);
    wait_done(d0);
    repeat (5) @(negedge clk);
    chk("short_done_once", done_cnt, d0 + 1);
    chk("short_words", bus.o_words_loaded, 3);
    chk("short_ram0", mirror[0], 8'hA5);
    chk("short_ram1", mirror[1], 8'h5A);

    // Execution reads.
    bus.i_mar_address = 4'd2; bus.i_ram_read = 1'b1;
    @(negedge clk);
    chk("exec_addr", bus.o_address, 2);
    chk("exec_en", bus.o_ram_enable, 1);
    chk("exec_bus", mirror[bus.o_address], 8'hFF);
    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom_range(0, 15));
      bus.i_mar_address = a;
      @(negedge clk);
      chk("rand_read_addr", bus.o_address, a);
      chk("rand_read_bus", mirror[bus.o_address], model_ram[a]);
    end

    // Start collides with a read in RUN, then a read during ACCEPT.
    last = 4'($urandom_range(0, 5));
    fill_src(int'(last) + 1);
    d0 = done_cnt;
    start_load(last, 1);
    chk("collide_en", bus.o_ram_enable, 0);
    @(negedge clk);
    bus.i_ram_read = 1'b0;
    chk("conflict_set", bus.o_conflict, 1);
    chk("conflict_en", bus.o_ram_enable, 0);
    run_bytes(int'(last) + 1, 1, -1);
    wait_done(d0);
    chk("conflict_sticky", bus.o_conflict, 1);

    // Start pulsed during SETUP must not disturb the load.
    fill_src(4);
    d0 = done_cnt;
    start_load(4'd3, 1);
    chk("conflict_cleared", bus.o_conflict, 0);
    run_bytes(4, 0, 0);
    wait_done(d0);
    chk("ignored_start_words", bus.o_words_loaded, 4);

    // Randomized loads.
    for (int r = 0; r < 4; r++) begin
      last = 4'($urandom_range(0, 15));
      fill_src(int'(last) + 1);
      d0 = done_cnt;
      start_load(last, 1);
      run_bytes(int'(last) + 1, int'($urandom_range(0, 2)), -1);
      wait_done(d0);
    end
    for (int i = 0; i < 16; i++) chk("ram_contents", mirror[i], model_ram[i]);

    // Reset after two of four bytes; start/valid held high with it.
    fill_src(2);
    d0 = done_cnt;
    start_load(4'd3, 0);
    run_bytes(2, 0, -1);
    @(negedge clk);
    rst = 1'b1; bus.i_start = 1'b1; bus.i_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.i_start = 1'b0; bus.i_valid = 1'b0;
    chk("abort_busy", bus.o_busy, 0);
    chk("abort_ready", bus.o_ready, 0);
    chk("abort_mode", bus.o_program_mode, 1);
    chk("abort_pdata", bus.o_program_data, 0);
    chk("abort_addr", bus.o_address, 0);
    chk("abort_words", bus.o_words_loaded, 0);
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    for (int i = 0; i < 4; i++) chk("abort_ram", mirror[i], model_ram[i]);

    chk("writes_pending", exp_wa.size(), 0);
    chk("done_pending", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
